// File: rtl/conv_layer_scheduler_pkg.sv
// Shared types and defaults for the conv/pool layer scheduler.
package conv_layer_scheduler_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_W,
      DISPATCH,
      DRAIN,
      FINISH
   } sched_state_t;

   // Default layer geometry shared with the conv/pool layers.
   localparam int DEF_IC        = 4;
   localparam int DEF_OC        = 8;
   localparam int DEF_NUM_CORES = 2;
   localparam int DEF_POOL_SIZE = 14;

   // Index width for n items, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_layer_scheduler_if.sv
// Weight RAM, core array and result buffer signals of one layer scheduler.
interface conv_layer_scheduler_if
   import conv_layer_scheduler_pkg::*;
#(
   parameter int IC        = DEF_IC,
   parameter int OC        = DEF_OC,
   parameter int NUM_CORES = DEF_NUM_CORES,
   parameter int POOL_SIZE = DEF_POOL_SIZE
);
   localparam int WW = IC * 9;
   localparam int PB = POOL_SIZE * POOL_SIZE;
   localparam int AW = idx_w(OC);

   logic                          wt_rd_en;
   logic [AW-1:0]                 wt_addr;
   logic [WW-1:0]                 wt_data;
   logic [NUM_CORES-1:0]          core_go;
   logic [NUM_CORES-1:0][WW-1:0]  core_wt;
   logic [NUM_CORES-1:0]          core_done;
   logic [NUM_CORES-1:0][PB-1:0]  core_res;
   logic                          res_we;
   logic [AW-1:0]                 res_addr;
   logic [PB-1:0]                 res_data;

   modport master (
      output wt_rd_en, wt_addr,
      input  wt_data,
      output core_go, core_wt,
      input  core_done, core_res,
      output res_we, res_addr, res_data
   );

   modport slave (
      input  wt_rd_en, wt_addr,
      output wt_data,
      input  core_go, core_wt,
      output core_done, core_res,
      input  res_we, res_addr, res_data
   );

endinterface

// File: rtl/conv_layer_scheduler_slot.sv
// One core slot: request level, channel tag and the weight held for the core.
module conv_core_slot #(
   parameter int WW = 36,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          clr,
   input  logic [WW-1:0] wt_in,
   input  logic [AW-1:0] tag_in,
   input  logic          core_done,
   output logic          go,
   output logic [AW-1:0] tag,
   output logic [WW-1:0] wt,
   output logic          idle
);

   // A slot is reusable only once the core has also dropped its done level.
   assign idle = !go && !core_done;

   // Load raises go with its weight and tag together; collection drops go.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         go  <= 1'b0;
         tag <= '0;
         wt  <= '0;
      end else if (load) begin
         go  <= 1'b1;
         tag <= tag_in;
         wt  <= wt_in;
      end else if (clr) begin
         go  <= 1'b0;
      end
   end

endmodule

// File: rtl/conv_layer_scheduler.sv
// Sequences one Conv2d+MaxPool2d layer over a pool of shared cores: fetches
// per-channel weights, dispatches to idle cores, collects results in any order.
module conv_layer_scheduler
   import conv_layer_scheduler_pkg::*;
#(
   parameter int IC        = DEF_IC,
   parameter int OC        = DEF_OC,
   parameter int NUM_CORES = DEF_NUM_CORES,
   parameter int POOL_SIZE = DEF_POOL_SIZE
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   conv_layer_scheduler_if.master bus
);
   localparam int WW = IC * 9;
   localparam int PB = POOL_SIZE * POOL_SIZE;
   localparam int AW = idx_w(OC);
   localparam int KW = idx_w(NUM_CORES);
   localparam int NW = $clog2(OC + 1);

   sched_state_t                  state;
   logic [NW-1:0]                 next_oc;
   logic [KW-1:0]                 sel_k;
   logic [KW-1:0]                 idle_k;
   logic [KW-1:0]                 coll_k;
   logic                          coll_hit;
   logic                          coll_en;
   logic                          rd_en;
   logic [AW-1:0]                 rd_addr;
   logic                          we;
   logic [AW-1:0]                 waddr;
   logic [PB-1:0]                 wdata;
   logic [NUM_CORES-1:0]          slot_go;
   logic [NUM_CORES-1:0]          slot_idle;
   logic [NUM_CORES-1:0]          slot_load;
   logic [NUM_CORES-1:0]          slot_clr;
   logic [NUM_CORES-1:0][AW-1:0]  slot_tag;
   logic [NUM_CORES-1:0][WW-1:0]  slot_wt;

   assign bus.wt_rd_en = rd_en;
   assign bus.wt_addr  = rd_addr;
   assign bus.core_go  = slot_go;
   assign bus.core_wt  = slot_wt;
   assign bus.res_we   = we;
   assign bus.res_addr = waddr;
   assign bus.res_data = wdata;

   // Collection is live in every non-IDLE state, in parallel with dispatch.
   assign coll_en = coll_hit && (state != IDLE);

   // Lowest-index priority encoders: idle slot for dispatch, finished slot for collection.
   always_comb begin
      idle_k   = '0;
      coll_k   = '0;
      coll_hit = 1'b0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         if (slot_idle[k]) idle_k = KW'(k);
         if (slot_go[k] && bus.core_done[k]) begin
            coll_k   = KW'(k);
            coll_hit = 1'b1;
         end
      end
   end

   // Per-slot load and clear strobes decoded from the selected indices.
   always_comb begin
      slot_load = '0;
      slot_clr  = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         slot_load[k] = (state == DISPATCH) && (sel_k == KW'(k));
         slot_clr[k]  = coll_en && (coll_k == KW'(k));
      end
   end

   for (genvar k = 0; k < NUM_CORES; k++) begin : g_slot
      conv_core_slot #(
         .WW (WW),
         .AW (AW)
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (slot_load[k]),
         .clr       (slot_clr[k]),
         .wt_in     (bus.wt_data),
         .tag_in    (next_oc[AW-1:0]),
         .core_done (bus.core_done[k]),
         .go        (slot_go[k]),
         .tag       (slot_tag[k]),
         .wt        (slot_wt[k]),
         .idle      (slot_idle[k])
      );
   end

   // Layer sequencer. The read issued in FETCH returns during DISPATCH, which is
   // where the chosen slot captures the weight and raises go in the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         rd_en   <= 1'b0;
         rd_addr <= '0;
         next_oc <= '0;
         sel_k   <= '0;
      end else begin
         done  <= 1'b0;
         rd_en <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  next_oc <= '0;
                  busy    <= 1'b1;
                  state   <= FETCH;
               end
            end
            FETCH: begin
               if (|slot_idle) begin
                  rd_en   <= 1'b1;
                  rd_addr <= next_oc[AW-1:0];
                  state   <= WAIT_W;
               end
            end
            WAIT_W: begin
               // Nothing can claim an idle slot before DISPATCH, so this pick holds.
               sel_k <= idle_k;
               state <= DISPATCH;
            end
            DISPATCH: begin
               next_oc <= next_oc + 1'b1;
               state   <= (int'(next_oc) + 1 < OC) ? FETCH : DRAIN;
            end
            DRAIN: begin
               if (&slot_idle) state <= FINISH;
            end
            FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Registered single-cycle result write for the collected slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we    <= 1'b0;
         waddr <= '0;
         wdata <= '0;
      end else begin
         we <= coll_en;
         if (coll_en) begin
            waddr <= slot_tag[coll_k];
            wdata <= bus.core_res[coll_k];
         end
      end
   end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Bench for conv_layer_scheduler: weight RAM and core models, scoreboard on
// result writes, table of layer scenarios plus reset and OC=1 sequences.
module tb_conv_layer_scheduler;
   localparam int WW = 36;
   localparam int PB = 196;

   typedef struct {
      int lat0;
      int lat1;
      bit dup;
      int first_addr;
      bit b2b;
   } vec_t;

   typedef struct {
      int            addr;
      logic [PB-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic start8, start1;
   logic busy8, done8, busy1, done1;

   always #5 clk = ~clk;

   conv_layer_scheduler_if #(.IC(4), .OC(8), .NUM_CORES(2), .POOL_SIZE(14)) bus8 ();
   conv_layer_scheduler_if #(.IC(4), .OC(1), .NUM_CORES(2), .POOL_SIZE(14)) bus1 ();

   conv_layer_scheduler #(.IC(4), .OC(8), .NUM_CORES(2), .POOL_SIZE(14)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8), .bus(bus8.master));
   conv_layer_scheduler #(.IC(4), .OC(1), .NUM_CORES(2), .POOL_SIZE(14)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .bus(bus1.master));

   function automatic logic [WW-1:0] wt_val(input int ch);
      logic [3:0] h;
      h = 4'(ch) ^ 4'h9;
      return {h, 32'h5A5A_0000 | 32'(ch)};
   endfunction

   function automatic logic [PB-1:0] res_val(input int ch);
      logic [27:0] s;
      s = 28'(ch) * 28'h0123457 + 28'h00ABCDE;
      return {7{s}};
   endfunction

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Weight RAMs: data one cycle after the read strobe.
   always @(posedge clk) if (bus8.wt_rd_en) bus8.wt_data <= wt_val(int'(bus8.wt_addr));
   always @(posedge clk) if (bus1.wt_rd_en) bus1.wt_data <= wt_val(int'(bus1.wt_addr));

   int lat [2];
   int chan8 [2];

   // Core models: done level lat cycles after go rises, cleared once go drops.
   for (genvar k = 0; k < 2; k++) begin : g_core
      int   cnt8 = 0;
      logic cd8  = 1'b0;
      int   cnt1 = 0;
      logic cd1  = 1'b0;
      always @(posedge clk) begin
         if (!bus8.core_go[k]) begin
            cnt8 <= 0;
            cd8  <= 1'b0;
         end else if (!cd8) begin
            cnt8 <= cnt8 + 1;
            if (cnt8 + 1 >= lat[k]) cd8 <= 1'b1;
         end
         if (!bus1.core_go[k]) begin
            cnt1 <= 0;
            cd1  <= 1'b0;
         end else if (!cd1) begin
            cnt1 <= cnt1 + 1;
            if (cnt1 + 1 >= 4) cd1 <= 1'b1;
         end
      end
      assign bus8.core_done[k] = cd8;
      assign bus8.core_res[k]  = res_val(chan8[k]);
      assign bus1.core_done[k] = cd1;
      assign bus1.core_res[k]  = res_val(0);
   end

   // Scoreboard state owned by the monitor.
   exp_t exp_q[$];
   int   wr_addr_log[$];
   time  wr_t_log[$];
   int   disp8 = 0;
   int   sb_bad = 0;
   int   ndone8 = 0;
   time  first_go_t = 0;
   logic [1:0] go_prev8 = 2'b00;
   logic [1:0] go1_mask = 2'b00;
   int   nwr1 = 0;
   int   ndone1 = 0;
   int   wr1_addr = -1;
   logic [PB-1:0] wr1_data = '0;

   // Monitor: push expected result on each dispatch, match each write against it.
   always @(negedge clk) begin : mon
      int hit;
      if (!rst_n) begin
         exp_q.delete();
         disp8    = 0;
         go_prev8 = 2'b00;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (bus8.core_go[k] && !go_prev8[k]) begin
               chan8[k] = disp8;
               if (disp8 == 0) first_go_t = $time;
               if (bus8.core_wt[k] !== wt_val(disp8)) begin
                  sb_bad++;
                  $display("FAIL core_wt[%0d]: got %0h expected %0h", k, bus8.core_wt[k], wt_val(disp8));
               end
               exp_q.push_back('{addr: disp8, data: res_val(disp8)});
               disp8++;
            end
         end
         go_prev8 = bus8.core_go;
         if (bus8.res_we) begin
            wr_addr_log.push_back(int'(bus8.res_addr));
            wr_t_log.push_back($time);
            hit = -1;
            foreach (exp_q[j]) if (hit < 0 && exp_q[j].addr == int'(bus8.res_addr)) hit = j;
            if (hit < 0) begin
               sb_bad++;
               $display("FAIL sb_addr: got write to %0d expected an outstanding channel", bus8.res_addr);
            end else begin
               if (bus8.res_data !== exp_q[hit].data) begin
                  sb_bad++;
                  $display("FAIL sb_data[%0d]: got %0h expected %0h", bus8.res_addr, bus8.res_data, exp_q[hit].data);
               end
               exp_q.delete(hit);
            end
         end
         if (done8) begin
            ndone8++;
            disp8 = 0;
         end
         go1_mask = go1_mask | bus1.core_go;
         if (bus1.res_we) begin
            nwr1++;
            wr1_addr = int'(bus1.res_addr);
            wr1_data = bus1.res_data;
         end
         if (done1) ndone1++;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic run_layer(input vec_t v);
      int   n0, d0, b0, nw;
      bit   seen;
      time  ts;
      logic [7:0] m;
      lat[0] = v.lat0;
      lat[1] = v.lat1;
      n0 = wr_addr_log.size();
      d0 = ndone8;
      b0 = sb_bad;
      tick();
      start8 = 1'b1;
      ts = $time - 1;
      tick();
      start8 = 1'b0;
      check("busy_after_start", busy8, 1);
      if (v.dup) begin
         repeat (3) tick();
         start8 = 1'b1;
         tick();
         start8 = 1'b0;
      end
      seen = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (ndone8 != d0) begin
            seen = 1;
            break;
         end
      end
      check("done_seen", seen, 1);
      check("busy_at_done", busy8, 0);
      repeat (10) tick();
      nw = wr_addr_log.size() - n0;
      m = '0;
      for (int j = n0; j < n0 + nw; j++) m[wr_addr_log[j][2:0]] = 1'b1;
      check("done_count", ndone8 - d0, 1);
      check("write_count", nw, 8);
      check("addr_cover", m, 8'hFF);
      check("sb_clean", sb_bad - b0, 0);
      check("sb_empty", exp_q.size(), 0);
      check("first_go_latency", (first_go_t - ts) / 10, 4);
      check("busy_idle", busy8, 0);
      if (nw > 0) check("first_addr", wr_addr_log[n0], v.first_addr);
      if (v.b2b && nw > 1) begin
         check("b2b_addr", wr_addr_log[n0+1], 1);
         check("b2b_gap", wr_t_log[n0+1] - wr_t_log[n0], 10);
      end
   endtask

   vec_t tbl [4];

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1);
   end

   initial begin
      int  d0, d1;
      bit  seen;
      tbl[0] = '{lat0: 5,  lat1: 5, dup: 0, first_addr: 0, b2b: 0};
      tbl[1] = '{lat0: 20, lat1: 3, dup: 0, first_addr: 1, b2b: 0};
      tbl[2] = '{lat0: 8,  lat1: 5, dup: 0, first_addr: 0, b2b: 1};
      tbl[3] = '{lat0: 5,  lat1: 5, dup: 1, first_addr: 0, b2b: 0};
      lat[0] = 5;
      lat[1] = 5;
      rst_n  = 1'b0;
      start8 = 1'b0;
      start1 = 1'b0;
      repeat (3) tick();
      check("rst_busy", busy8, 0);
      check("rst_done", done8, 0);
      check("rst_go", bus8.core_go, 0);
      check("rst_we", bus8.res_we, 0);
      check("rst_rd_en", bus8.wt_rd_en, 0);
      check("rst_res_data", bus8.res_data, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 4; i++) run_layer(tbl[i]);

      // Reset with two channels in flight.
      lat[0] = 30;
      lat[1] = 30;
      d0 = ndone8;
      tick();
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      seen = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (bus8.core_go == 2'b11) begin
            seen = 1;
            break;
         end
      end
      check("two_in_flight", seen, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_go", bus8.core_go, 0);
      check("midrst_busy", busy8, 0);
      check("midrst_we", bus8.res_we, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      check("midrst_no_done", ndone8 - d0, 0);
      run_layer(tbl[0]);

      // OC=1 instance: a single channel on core 0.
      d1 = ndone1;
      tick();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      seen = 0;
      for (int c = 0; c < 500; c++) begin
         tick();
         if (ndone1 != d1) begin
            seen = 1;
            break;
         end
      end
      check("oc1_done_seen", seen, 1);
      repeat (5) tick();
      check("oc1_go_mask", go1_mask, 2'b01);
      check("oc1_writes", nwr1, 1);
      check("oc1_addr", wr1_addr, 0);
      check("oc1_data", wr1_data, res_val(0));
      check("oc1_done_count", ndone1 - d1, 1);
      check("oc1_busy_idle", busy1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
